// File: rtl/stopwatch_bcd_pkg.sv
// rtl/stopwatch_bcd_pkg.sv - shared state encodings, digit indices and BCD width for the stopwatch
package stopwatch_bcd_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 6;

    // Digit positions inside the packed display word, least significant first
    localparam int DIG_CS_U  = 0;
    localparam int DIG_CS_T  = 1;
    localparam int DIG_SEC_U = 2;
    localparam int DIG_SEC_T = 3;
    localparam int DIG_MIN_U = 4;
    localparam int DIG_MIN_T = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Tens and units of a small constant, used to hold MAX_MIN in BCD form
    function automatic logic [BCD_W-1:0] bcd_tens(input int v);
        return BCD_W'(v / 10);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_units(input int v);
        return BCD_W'(v % 10);
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// rtl/stopwatch_bcd_digit_cnt.sv - single BCD digit counter 0..LIMIT with ripple carry out
module bcd_digit_cnt
    import stopwatch_bcd_pkg::*;
#(
    parameter logic [BCD_W-1:0] LIMIT = 4'd9
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] r_q;

    // Clear has priority over counting so a clear coincident with a step lands on zero
    always_ff @(posedge clkin) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == LIMIT) ? '0 : r_q + 1'b1;
        end
    end

    assign q     = r_q;
    assign carry = en & (r_q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - mm:ss.cc BCD stopwatch; optional lap hold via STOPWATCH_LAP_HOLD_EN
module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] digits,
    output logic        run,
    output logic        ovf,
    output logic [1:0]  state_o
);

    localparam logic [BCD_W-1:0] MAX_MIN_T = bcd_tens(MAX_MIN);
    localparam logic [BCD_W-1:0] MAX_MIN_U = bcd_units(MAX_MIN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_tick_d;
    logic             r_run;
    logic             r_ovf;
    logic [BCD_W-1:0] r_min_t;
    logic [BCD_W-1:0] r_min_u;

    logic             w_step;
    logic             w_en;
    logic [BCD_W-1:0] w_cs_u, w_cs_t, w_sec_u, w_sec_t;
    logic             w_c_cs_u, w_c_cs_t, w_c_sec_u, w_c_sec_t;
    logic             w_min_max;
    logic             w_wrap;
    logic [23:0]      w_live;

    // Delay the divided clock by one cycle for rising-edge detection
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= tick_in;
        end
    end

    assign w_step = tick_in & ~r_tick_d;
    assign w_en   = (r_state == ST_RUN) & w_step;

    // State register
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clear beats start_stop; the unused encoding falls back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start_stop) w_state_nxt = ST_RUN;
                ST_RUN:   if (start_stop) w_state_nxt = ST_PAUSE;
                ST_PAUSE: if (start_stop) w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // run follows the state register so the divider pauses together with the count
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= (w_state_nxt == ST_RUN);
        end
    end

    bcd_digit_cnt #(.LIMIT(4'd9)) u_cs_u (
        .clkin(clkin), .rst(rst), .clr(clear), .en(w_en),
        .q(w_cs_u), .carry(w_c_cs_u)
    );

    bcd_digit_cnt #(.LIMIT(4'd9)) u_cs_t (
        .clkin(clkin), .rst(rst), .clr(clear), .en(w_c_cs_u),
        .q(w_cs_t), .carry(w_c_cs_t)
    );

    bcd_digit_cnt #(.LIMIT(4'd9)) u_sec_u (
        .clkin(clkin), .rst(rst), .clr(clear), .en(w_c_cs_t),
        .q(w_sec_u), .carry(w_c_sec_u)
    );

    bcd_digit_cnt #(.LIMIT(4'd5)) u_sec_t (
        .clkin(clkin), .rst(rst), .clr(clear), .en(w_c_sec_u),
        .q(w_sec_t), .carry(w_c_sec_t)
    );

    assign w_min_max = (r_min_t == MAX_MIN_T) && (r_min_u == MAX_MIN_U);
    assign w_wrap    = w_c_sec_t & w_min_max;

    // Two-digit BCD minutes, wrapping to 00 after MAX_MIN
    always_ff @(posedge clkin) begin
        if (rst || clear) begin
            r_min_t <= '0;
            r_min_u <= '0;
        end else if (w_c_sec_t) begin
            if (w_min_max) begin
                r_min_t <= '0;
                r_min_u <= '0;
            end else if (r_min_u == 4'd9) begin
                r_min_t <= r_min_t + 1'b1;
                r_min_u <= '0;
            end else begin
                r_min_u <= r_min_u + 1'b1;
            end
        end
    end

    // Sticky overflow, cleared only by clear or reset
    always_ff @(posedge clkin) begin
        if (rst || clear) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_live = {r_min_t, r_min_u, w_sec_t, w_sec_u, w_cs_t, w_cs_u};

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        r_lap_hold;
    logic [23:0] r_shadow;

    // lap toggles the hold while staying in RUN; the shadow snapshots the pre-step live count
    always_ff @(posedge clkin) begin
        if (rst || clear) begin
            r_lap_hold <= 1'b0;
            r_shadow   <= '0;
        end else if (w_state_nxt != ST_RUN) begin
            r_lap_hold <= 1'b0;
        end else if (lap && (r_state == ST_RUN)) begin
            if (!r_lap_hold) begin
                r_shadow <= w_live;
            end
            r_lap_hold <= ~r_lap_hold;
        end
    end

    assign digits = r_lap_hold ? r_shadow : w_live;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign digits       = w_live;
`endif

    assign run     = r_run;
    assign ovf     = r_ovf;
    assign state_o = r_state;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - scoreboard bench running MAX_MIN=59 and MAX_MIN=1 instances side by side
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    localparam int LIM59 = 60 * 6000;
    localparam int LIM1  = 2 * 6000;

    logic        clkin = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [23:0] digits59, digits1;
    logic        run59, run1, ovf59, ovf1;
    logic [1:0]  st59, st1;

    always #10 clkin = ~clkin;

    stopwatch_bcd u_dut59 (
        .clkin(clkin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .digits(digits59), .run(run59), .ovf(ovf59),
        .state_o(st59)
    );

    stopwatch_bcd #(.MAX_MIN(1)) u_dut1 (
        .clkin(clkin), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .digits(digits1), .run(run1), .ovf(ovf1),
        .state_o(st1)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    int  m_state = 0;
    int  cnt59 = 0, cnt1 = 0;
    bit  m_ovf59 = 0, m_ovf1 = 0;
    bit  m_tick_d = 0;
    bit  m_hold = 0;
    int  sh59 = 0, sh1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int c);
        int cs, s, m;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return {8'd0, digits59};
            1: return {31'd0, run59};
            2: return {31'd0, ovf59};
            3: return {30'd0, st59};
            4: return {8'd0, digits1};
            5: return {31'd0, run1};
            6: return {31'd0, ovf1};
            default: return {30'd0, st1};
        endcase
    endfunction

    function automatic logic [23:0] disp(input int live, input int sh);
        return (LAP && m_hold) ? to_bcd(sh) : to_bcd(live);
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic expect_all(input string tag);
        push({tag, ".dig59"}, 0, {8'd0, disp(cnt59, sh59)});
        push({tag, ".run59"}, 1, {31'd0, m_state == 1});
        push({tag, ".ovf59"}, 2, {31'd0, m_ovf59});
        push({tag, ".st59"},  3, 32'(m_state));
        push({tag, ".dig1"},  4, {8'd0, disp(cnt1, sh1)});
        push({tag, ".run1"},  5, {31'd0, m_state == 1});
        push({tag, ".ovf1"},  6, {31'd0, m_ovf1});
        push({tag, ".st1"},   7, 32'(m_state));
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic adv(inout int c, inout bit o, input int lim);
        c = c + 1;
        if (c == lim) begin
            c = 0;
            o = 1'b1;
        end
    endtask

    // One clkin cycle: drive inputs after a falling edge, update the model, wait for the next falling edge
    task automatic cycle(input bit ss, input bit cl, input bit tk, input bit lp, input bit rs);
        bit stp, en;
        int nxt;
        start_stop = ss;
        clear      = cl;
        tick_in    = tk;
        lap        = lp;
        rst        = rs;
        if (rs) begin
            m_state = 0; cnt59 = 0; cnt1 = 0; m_ovf59 = 0; m_ovf1 = 0;
            m_tick_d = 0; m_hold = 0; sh59 = 0; sh1 = 0;
        end else begin
            stp = tk & ~m_tick_d;
            en  = (m_state == 1) && stp;
            nxt = m_state;
            if (cl) nxt = 0;
            else if (ss) nxt = (m_state == 1) ? 2 : 1;
            if (LAP) begin
                if (cl) begin
                    m_hold = 0; sh59 = 0; sh1 = 0;
                end else if (nxt != 1) begin
                    m_hold = 0;
                end else if (lp && m_state == 1) begin
                    if (!m_hold) begin
                        sh59 = cnt59;
                        sh1  = cnt1;
                    end
                    m_hold = !m_hold;
                end
            end
            if (cl) begin
                cnt59 = 0; cnt1 = 0; m_ovf59 = 0; m_ovf1 = 0;
            end else if (en) begin
                adv(cnt59, m_ovf59, LIM59);
                adv(cnt1, m_ovf1, LIM1);
            end
            m_tick_d = tk;
            m_state  = nxt;
        end
        @(negedge clkin);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clkin);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        expect_all("reset");
        drain();

        cycle(1, 0, 0, 0, 0);
        ticks(250);
        expect_all("run_250");
        drain();
        cycle(1, 0, 0, 0, 0);
        ticks(100);
        expect_all("pause_hold");
        drain();

        cycle(1, 0, 0, 0, 0);
        ticks(5749);
        expect_all("at_59_99");
        drain();
        push("pre_edge.dig59", 0, {8'd0, to_bcd(cnt59)});
        tick_in = 1'b1;
        #3;
        drain();
        cycle(0, 0, 1, 0, 0);
        expect_all("full_ripple");
        drain();
        cycle(0, 0, 0, 0, 0);

        ticks(5999);
        expect_all("at_1_59_99");
        drain();
        ticks(1);
        expect_all("wrap");
        drain();
        ticks(5);
        expect_all("after_wrap");
        drain();
        cycle(0, 1, 0, 0, 0);
        expect_all("clear_ovf");
        drain();

        cycle(1, 0, 0, 0, 0);
        ticks(8345);
        expect_all("at_1_23_45");
        drain();
        cycle(0, 0, 1, 0, 1);
        expect_all("rst_mid");
        drain();
        cycle(0, 0, 0, 0, 0);

        cycle(1, 0, 0, 0, 0);
        ticks(100);
        cycle(0, 0, 0, 1, 0);
        expect_all("lap_on");
        drain();
        ticks(100);
        expect_all("lap_frozen");
        drain();
        cycle(0, 0, 0, 1, 0);
        expect_all("lap_off");
        drain();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        ticks(3);
        expect_all("lap_in_pause");
        drain();

        cycle(1, 0, 0, 0, 0);
        ticks(7);
        cycle(1, 1, 0, 0, 0);
        expect_all("clear_beats_ss");
        drain();

        cycle(1, 0, 0, 0, 0);
        ticks(3);
        cycle(1, 0, 1, 0, 0);
        expect_all("ss_with_step");
        drain();
        cycle(0, 0, 0, 0, 0);

        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        expect_all("tick_stuck_high");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Downstream consumer of the 100 Hz divided clock produced by the team's clock divider; counts elapsed time as mm:ss.cc in BCD.
- Runs entirely in the clkin domain. The divided clock enters as a level signal on tick_in; its rising edge is detected internally.
- Drives run back to the divider's clken so the divider pauses with the stopwatch.
- Outputs feed the 7-segment scan stage.

Parameters:
- MAX_MIN, 59, highest minutes value before wrap; range 1..99, BCD-encoded internally.

Ports:
- clkin  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- tick_in  input  1  divided clock from the divider (100 Hz square wave)
- start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause
- clear  input  1  single-cycle pulse, already debounced; return to zero
- lap  input  1  single-cycle pulse; used only when LAP_HOLD_EN is defined, otherwise ignored
- digits  output  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4-bit BCD each, MSB first
- run  output  1  high in RUN; intended for the divider's clken
- ovf  output  1  sticky flag, set on wrap past MAX_MIN:59.99
- state_o  output  2  current FSM state, for debug and verification

Behaviour:
- Reset (rst=1 at a clkin edge): digits=0, run=0, ovf=0, state=IDLE, tick_d=0. Reset overrides every other input, including mid-count.
- Edge detect:
  - tick_d <= tick_in every cycle.
  - step = tick_in & ~tick_d (combinational).
  - With the divider's square wave this gives exactly one step per tick period.
- FSM, states IDLE=0, RUN=1, PAUSE=2 (3 unused; decodes to IDLE on the next edge):
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - clear in any state -> IDLE; digits cleared to 0 and ovf cleared on the same edge.
  - clear and start_stop in the same cycle: clear wins; next state is IDLE.
- Counting:
  - Enable = (current state == RUN) & step.
  - Digits change on the same clkin edge that registers step, i.e. one clkin cycle after tick_in is first sampled high.
  - A step arriving in the cycle that start_stop leaves RUN is still counted. A step in the cycle that start_stop enters RUN is not counted.
- Digit rules:
  - cs_u 0..9, then carry into cs_t.
  - cs_t 0..9, then carry into sec_u.
  - sec_u 0..9, then carry into sec_t.
  - sec_t 0..5, then carry into minutes.
  - Minutes {min_t, min_u} are BCD, 00..MAX_MIN.
  - All carries ripple within a single cycle.
- Wrap: at MAX_MIN:59.99 the next enabled step sets all digits to 00:00.00 and sets ovf=1. ovf holds until clear or rst. The count continues after wrap.
- run is registered: run = (state == RUN), valid from the cycle after the transition.
- PAUSE holds digits. IDLE holds zeros. Steps are ignored in both.
- tick_in stuck high: no further steps. tick_in stuck low: no steps.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds a lap_hold register and a shadow digit register.
  - lap in RUN toggles lap_hold. When entering hold, the shadow captures the live count.
  - While lap_hold=1, digits shows the shadow and the live count continues underneath.
  - Leaving RUN (start_stop or clear) clears lap_hold.
  - lap in IDLE or PAUSE has no effect.
  - clear resets the shadow to 0.
- Not defined: lap input unconnected internally; digits always shows the live count; no shadow register.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE.
  - Digit-field index constants.
  - BCD_W=4.
- Natural sub-module: bcd_digit_cnt.
  - Parameter LIMIT.
  - Inputs: clkin, rst, clr, en.
  - Outputs: q[3:0], carry. carry = en & (q == LIMIT).
  - Instantiated four times (cs_u, cs_t, sec_u, sec_t).
  - Minutes use the 2-digit compare against MAX_MIN in the top level.

Test Plan:
- rst mid-count at 01:23.45 -> next edge: digits=0, run=0, ovf=0, state=IDLE.
- start_stop, then 250 tick_in periods -> digits=00:02.50, run=1; start_stop again, then 100 ticks -> still 00:02.50, state=PAUSE.
- Preload (run ticks) to 00:59.99, one more tick -> 01:00.00 within the same cycle (full carry ripple); digit update lands exactly one clkin cycle after tick_in rises.
- MAX_MIN=1, run to 01:59.99, one more tick -> 00:00.00 and ovf=1; 5 more ticks -> 00:00.05 with ovf still 1; clear -> ovf=0.
- clear and start_stop in the same cycle while in RUN -> IDLE with digits=0; start_stop coincident with step while in RUN -> step counted, state=PAUSE.
- STOPWATCH_LAP_HOLD_EN defined: lap at 00:01.00, run 100 more ticks -> digits shows 00:01.00; lap again -> shows 00:02.00.
